// File: rtl/axis_common_pkg.sv
// Shared helpers for the AXI4-Stream width converters (upsizer and downsizer):
// lane-ratio / counter-width derivation, the cfg clamp and the lane-select test.
// Both converters use cfg = words-1, so the same helpers keep them in lock-step.
package axis_common_pkg;

  // Narrow words per wide word.
  function automatic int calc_ratio(input int m_width, input int s_width);
    return m_width / s_width;
  endfunction

  // Width of the lane counter; a RATIO of 1 still gets a 1-bit counter.
  function automatic int calc_cntr_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Clamp a requested words-1 value to the largest the datapath can hold.
  function automatic logic [15:0] clamp_cfg(input logic [15:0] cfg, input int ratio);
    int cfg_i;
    cfg_i = int'(cfg);
    if (cfg_i >= ratio) begin
      return 16'(ratio - 1);
    end
    return cfg;
  endfunction

  // A lane holds collected data only if it sits below the current lane pointer.
  function automatic logic lane_below(input int lane, input int cnt);
    return lane < cnt;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Purpose: single-entry registered output stage (data/valid/ready), areset active-high.
// Latency: 1 cycle from in_vld&in_rdy to out_vld.
// Backpressure: in_rdy = ~out_vld | out_rdy, so a full stage refills on the cycle it drains.
module axis_out_reg #(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] in_dat,
  input  logic                  in_vld,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_dat,
  output logic                  out_vld,
  input  logic                  out_rdy
);

  assign in_rdy = ~out_vld | out_rdy;

  // Load on accept; otherwise drop valid once the consumer takes the word.
  always_ff @(posedge aclk) begin
    if (areset) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (in_vld && in_rdy) begin
      out_vld <= 1'b1;
      out_dat <= in_dat;
    end else if (out_rdy) begin
      out_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_upsizer.sv
// Purpose: packs N narrow AXI4-Stream beats (N = cfg_data+1, lowest lane first) into one wide word.
// Latency: 1 cycle from the word's last input beat to m_axis_tvalid.
// Backpressure: only a word-completing beat can stall, and only while the output stage is full and not drained.
// Optional macro AXIS_UPSIZER_TLAST_EN adds s_axis_tlast/m_axis_tlast; a tlast beat closes the word early.
module axis_upsizer
  import axis_common_pkg::*;
#(
  parameter int S_AXIS_TDATA_WIDTH = 32,
  parameter int M_AXIS_TDATA_WIDTH = 128
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [15:0]                   cfg_data,
  input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
`ifdef AXIS_UPSIZER_TLAST_EN
  input  logic                          s_axis_tlast,
  output logic                          m_axis_tlast,
`endif
  output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready
);

  localparam int RATIO      = calc_ratio(M_AXIS_TDATA_WIDTH, S_AXIS_TDATA_WIDTH);
  localparam int CNTR_WIDTH = calc_cntr_width(RATIO);
  localparam int ACC_LANES  = (RATIO > 1) ? RATIO - 1 : 1;
`ifdef AXIS_UPSIZER_TLAST_EN
  localparam int OUT_WIDTH  = M_AXIS_TDATA_WIDTH + 1;
`else
  localparam int OUT_WIDTH  = M_AXIS_TDATA_WIDTH;
`endif

  logic [CNTR_WIDTH-1:0]                         cnt;
  logic [CNTR_WIDTH-1:0]                         lim;
  logic [CNTR_WIDTH-1:0]                         cfg_lim;
  logic [CNTR_WIDTH-1:0]                         eff_lim;
  logic [ACC_LANES-1:0][S_AXIS_TDATA_WIDTH-1:0]  acc;
  logic [M_AXIS_TDATA_WIDTH-1:0]                 word;
  logic                                          beat_last;
  logic                                          completes;
  logic                                          accept;
  logic                                          out_in_rdy;
  logic [OUT_WIDTH-1:0]                          out_in_dat;
  logic [OUT_WIDTH-1:0]                          out_dat;

  // A new word picks up cfg_data on its first beat; mid-word the latched limit rules.
  assign cfg_lim = CNTR_WIDTH'(clamp_cfg(cfg_data, RATIO));
  assign eff_lim = (cnt == '0) ? cfg_lim : lim;

`ifdef AXIS_UPSIZER_TLAST_EN
  assign beat_last = s_axis_tlast;
`else
  assign beat_last = 1'b0;
`endif

  // Only a completing beat needs room in the output stage.
  assign completes     = (cnt == eff_lim) | beat_last;
  assign s_axis_tready = ~completes | out_in_rdy;
  assign accept        = s_axis_tvalid & s_axis_tready;

  // Assemble the outgoing word: collected lanes below cnt, the live beat in lane cnt, zeros above.
  always_comb begin
    word = '0;
    for (int i = 0; i < ACC_LANES; i++) begin
      if (lane_below(i, int'(cnt))) begin
        word[i*S_AXIS_TDATA_WIDTH +: S_AXIS_TDATA_WIDTH] = acc[i];
      end
    end
    word[int'(cnt)*S_AXIS_TDATA_WIDTH +: S_AXIS_TDATA_WIDTH] = s_axis_tdata;
  end

  // Lane counter, latched limit and accumulator; a completing beat resets the word.
  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt <= '0;
      lim <= '0;
      acc <= '0;
    end else begin
      if (cnt == '0) begin
        lim <= cfg_lim;
      end
      if (accept) begin
        if (completes) begin
          cnt <= '0;
          acc <= '0;
        end else begin
          cnt <= cnt + CNTR_WIDTH'(1);
          for (int i = 0; i < ACC_LANES; i++) begin
            if (i == int'(cnt)) begin
              acc[i] <= s_axis_tdata;
            end
          end
        end
      end
    end
  end

`ifdef AXIS_UPSIZER_TLAST_EN
  assign out_in_dat   = {beat_last, word};
  assign m_axis_tdata = out_dat[M_AXIS_TDATA_WIDTH-1:0];
  assign m_axis_tlast = out_dat[M_AXIS_TDATA_WIDTH];
`else
  assign out_in_dat   = word;
  assign m_axis_tdata = out_dat;
`endif

  axis_out_reg #(
    .DATA_WIDTH (OUT_WIDTH)
  ) u_out_reg (
    .aclk    (aclk),
    .areset  (areset),
    .in_dat  (out_in_dat),
    .in_vld  (accept & completes),
    .in_rdy  (out_in_rdy),
    .out_dat (out_dat),
    .out_vld (m_axis_tvalid),
    .out_rdy (m_axis_tready)
  );

endmodule

// File: tb/tb_axis_upsizer.sv
// Bench for axis_upsizer (32 -> 128): directed cases plus a randomized run,
// all checked against a beat-list reference model of the packing rules.
// Build with AXIS_UPSIZER_TLAST_EN defined to also exercise early word close.
module tb_axis_upsizer;

  localparam int SW = 32;
  localparam int MW = 128;
  localparam int R  = MW / SW;

  logic           aclk = 1'b0;
  logic           areset = 1'b1;
  logic [15:0]    cfg_data = 16'd0;
  logic [SW-1:0]  s_axis_tdata = '0;
  logic           s_axis_tvalid = 1'b0;
  logic           s_axis_tready;
  logic [MW-1:0]  m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tready = 1'b0;
`ifdef AXIS_UPSIZER_TLAST_EN
  logic           s_axis_tlast = 1'b0;
  logic           m_axis_tlast;
`endif

  always #5 aclk = ~aclk;

  axis_upsizer #(
    .S_AXIS_TDATA_WIDTH (SW),
    .M_AXIS_TDATA_WIDTH (MW)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .cfg_data      (cfg_data),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
`ifdef AXIS_UPSIZER_TLAST_EN
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tlast  (m_axis_tlast),
`endif
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: beats of the word being collected, its target length,
  // words expected at the output (bit 128 = tlast), and words actually taken.
  logic [SW-1:0]  beats[$];
  int             cur_n = 1;
  logic [MW:0]    exp_q[$];
  logic [MW:0]    got_q[$];

  task automatic chk(input string tag, input logic [MW:0] got, input logic [MW:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int words_for(input int cfg);
    return ((cfg >= R) ? R - 1 : cfg) + 1;
  endfunction

  function automatic logic would_complete(input int cfg, input logic lst);
    int n;
    n = (beats.size() == 0) ? words_for(cfg) : cur_n;
    return (beats.size() + 1 == n) || lst;
  endfunction

  task automatic model_accept(input logic [SW-1:0] dat, input logic lst, input int cfg);
    logic [MW:0] w;
    if (beats.size() == 0) cur_n = words_for(cfg);
    beats.push_back(dat);
    if (beats.size() == cur_n || lst) begin
      w = '0;
      foreach (beats[i]) w[i*SW +: SW] = beats[i];
      w[MW] = lst;
      exp_q.push_back(w);
      beats.delete();
    end
  endtask

  // One clock: drive at negedge, settle, check outputs and ready against the model, then update it.
  task automatic step(input logic vld, input logic [SW-1:0] dat, input logic lst,
                      input logic [15:0] cfg, input logic mrdy, output logic accepted);
    logic pend;
    logic comp;
    logic [MW:0] obs;
    logic [MW:0] dummy;
    @(negedge aclk);
    s_axis_tvalid = vld;
    s_axis_tdata  = dat;
    cfg_data      = cfg;
    m_axis_tready = mrdy;
`ifdef AXIS_UPSIZER_TLAST_EN
    s_axis_tlast  = lst;
`endif
    #1;
    obs = {1'b0, m_axis_tdata};
`ifdef AXIS_UPSIZER_TLAST_EN
    obs[MW] = m_axis_tlast;
`endif
    pend = (exp_q.size() != 0);
    chk("m_vld", {128'd0, m_axis_tvalid}, {128'd0, pend});
    if (pend) chk("m_dat", obs, exp_q[0]);
    comp = would_complete(int'(cfg), lst);
    chk("s_rdy", {128'd0, s_axis_tready}, {128'd0, (!comp || !pend || mrdy)});
    if (m_axis_tvalid && mrdy && pend) begin
      got_q.push_back(obs);
      dummy = exp_q.pop_front();
    end
    accepted = vld && s_axis_tready;
    if (accepted) model_accept(dat, lst, int'(cfg));
  endtask

  // Present one beat until accepted (bounded), with the output always ready.
  task automatic send(input logic [SW-1:0] dat, input logic lst, input logic [15:0] cfg);
    logic a;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, dat, lst, cfg, 1'b1, a);
      if (a) return;
    end
    chk("send_timeout", 129'd0, 129'd1);
  endtask

  task automatic drain(input logic [15:0] cfg);
    logic a;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1'b0, '0, 1'b0, cfg, 1'b1, a);
    chk("drain", 129'(exp_q.size()), 129'd0);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset = 1'b1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    @(posedge aclk);
    #1;
    chk("rst_vld", {128'd0, m_axis_tvalid}, 129'd0);
    chk("rst_dat", {1'b0, m_axis_tdata}, 129'd0);
    @(negedge aclk);
    areset = 1'b0;
    exp_q.delete();
    beats.delete();
  endtask

  initial begin
    logic a;
    int   idx;
    logic [SW-1:0] bp_dat[8];
    logic [15:0]   rcfg;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("init_vld", {128'd0, m_axis_tvalid}, 129'd0);
    chk("init_dat", {1'b0, m_axis_tdata}, 129'd0);
    @(negedge aclk);
    areset = 1'b0;

    // Continuous packing, cfg=3
    got_q.delete();
    for (int d = 1; d <= 8; d++) begin
      step(1'b1, SW'(d), 1'b0, 16'd3, 1'b1, a);
      chk("cont_acc", {128'd0, a}, 129'd1);
    end
    drain(16'd3);
    chk("cont_w0", got_q[0], {1'b0, 128'h00000004_00000003_00000002_00000001});
    chk("cont_w1", got_q[1], {1'b0, 128'h00000008_00000007_00000006_00000005});

    // Narrow ratio, cfg=1
    got_q.delete();
    send(32'hA, 1'b0, 16'd1);
    send(32'hB, 1'b0, 16'd1);
    drain(16'd1);
    chk("narrow", got_q[0], {1'b0, 128'h00000000_00000000_0000000B_0000000A});

    // Passthrough, cfg=0
    got_q.delete();
    send(32'hDEADBEEF, 1'b0, 16'd0);
    send(32'h12345678, 1'b0, 16'd0);
    drain(16'd0);
    chk("pass_n", 129'(got_q.size()), 129'd2);
    chk("pass_w0", got_q[0], {1'b0, 128'h00000000_00000000_00000000_DEADBEEF});

    // Backpressure: output stalls after the first word
    got_q.delete();
    for (int i = 0; i < 8; i++) bp_dat[i] = SW'(i + 1);
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b1, bp_dat[idx], 1'b0, 16'd3, 1'b1, a);
      if (a) idx++;
    end
    for (int c = 0; c < 6; c++) begin
      step(1'b1, bp_dat[idx], 1'b0, 16'd3, 1'b0, a);
      if (a) idx++;
    end
    chk("bp_accepted", 129'(idx), 129'd7);
    for (int c = 0; c < 10 && idx < 8; c++) begin
      step(1'b1, bp_dat[idx], 1'b0, 16'd3, 1'b1, a);
      if (a) idx++;
    end
    drain(16'd3);
    chk("bp_n", 129'(got_q.size()), 129'd2);
    chk("bp_w0", got_q[0], {1'b0, 128'h00000004_00000003_00000002_00000001});
    chk("bp_w1", got_q[1], {1'b0, 128'h00000008_00000007_00000006_00000005});

    // cfg change mid-word is deferred to the next word
    got_q.delete();
    send(32'h1, 1'b0, 16'd3);
    send(32'h2, 1'b0, 16'd3);
    for (int d = 3; d <= 6; d++) send(SW'(d), 1'b0, 16'd1);
    drain(16'd1);
    chk("cfgchg_w0", got_q[0], {1'b0, 128'h00000004_00000003_00000002_00000001});
    chk("cfgchg_w1", got_q[1], {1'b0, 128'h00000000_00000000_00000006_00000005});

    // Clamp: cfg=7 behaves as cfg=3
    got_q.delete();
    for (int d = 'h21; d <= 'h24; d++) send(SW'(d), 1'b0, 16'd7);
    drain(16'd7);
    chk("clamp_n", 129'(got_q.size()), 129'd1);
    chk("clamp_w", got_q[0], {1'b0, 128'h00000024_00000023_00000022_00000021});

    // Reset mid-word discards the partial word
    got_q.delete();
    send(32'h31, 1'b0, 16'd3);
    send(32'h32, 1'b0, 16'd3);
    do_reset();
    for (int d = 'h41; d <= 'h44; d++) send(SW'(d), 1'b0, 16'd3);
    drain(16'd3);
    chk("rstmid_n", 129'(got_q.size()), 129'd1);
    chk("rstmid_w", got_q[0], {1'b0, 128'h00000044_00000043_00000042_00000041});

`ifdef AXIS_UPSIZER_TLAST_EN
    // Early close on tlast, next word restarts at lane 0
    got_q.delete();
    send(32'h1, 1'b0, 16'd3);
    send(32'h2, 1'b1, 16'd3);
    for (int d = 5; d <= 8; d++) send(SW'(d), 1'b0, 16'd3);
    drain(16'd3);
    chk("tlast_w0", got_q[0], {1'b1, 128'h00000000_00000000_00000002_00000001});
    chk("tlast_w1", got_q[1], {1'b0, 128'h00000008_00000007_00000006_00000005});
`endif

    // Randomized traffic with random valid, ready, cfg and (if present) tlast
    rcfg = 16'd3;
    for (int c = 0; c < 3000; c++) begin
      logic lst;
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 4))
          0: rcfg = 16'd0;
          1: rcfg = 16'd1;
          2: rcfg = 16'd2;
          3: rcfg = 16'd3;
          default: rcfg = 16'd7;
        endcase
      end
`ifdef AXIS_UPSIZER_TLAST_EN
      lst = ($urandom_range(0, 4) == 0);
`else
      lst = 1'b0;
`endif
      step($urandom_range(0, 9) < 7, $urandom, lst, rcfg,
           $urandom_range(0, 9) < 6, a);
      if (c == 1500) begin
        do_reset();
      end
    end
    drain(rcfg);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_upsizer.md
Name: axis_upsizer

Overview:
- Packs a stream of narrow AXI4-Stream words into wide words: S_AXIS_TDATA_WIDTH to M_AXIS_TDATA_WIDTH.
- The number of narrow words per wide word is run-time configurable.
- Sits directly upstream of the 128→32 downsizer in the DMA/ADC data path, with the same cfg_data convention. cfg = words−1, so a loop-back of upsizer→downsizer with equal cfg_data is lossless.
- Lane order is lowest lane first.

Parameters:
- S_AXIS_TDATA_WIDTH, 32, narrow input word width.
- M_AXIS_TDATA_WIDTH, 128, wide output word width. Must be an integer multiple of S_AXIS_TDATA_WIDTH.
- (derived, not overridable) RATIO = M/S; CNTR_WIDTH = RATIO>1 ? clog2(RATIO) : 1.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- cfg_data  in  16  bits [CNTR_WIDTH-1:0] = N−1, where N = narrow words per output word
- s_axis_tdata  in  S_AXIS_TDATA_WIDTH  input data
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  M_AXIS_TDATA_WIDTH  packed output
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- (macro only) s_axis_tlast in 1, m_axis_tlast out 1

Behaviour:
- One clock domain: aclk. Reset is synchronous and active-high (areset).
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, lane counter=0, accumulator=0, latched N−1 = 0, m_axis_tlast=0.
- Reset mid-word discards the partial word. Reset while m_axis_tvalid=1 drops the pending output.
- Storage: accumulator holding (RATIO−1) lanes, plus a registered output stage (data + valid).
- State is the lane counter cnt (0..N−1). No other FSM.
- Transfer: a beat is accepted when s_axis_tvalid & s_axis_tready.
- At cnt=0:
  - cfg_data[CNTR_WIDTH-1:0] is latched as lim.
  - If cfg_data ≥ RATIO, lim clamps to RATIO−1.
  - cfg changes at cnt≠0 are ignored until the next word.
- Accepted beat at cnt<lim: data is stored in lane cnt; cnt increments.
- Accepted beat at cnt=lim:
  - Output register loads {beat in lane lim, accumulator lanes 0..lim−1}.
  - Lanes above lim are zero.
  - m_axis_tvalid=1 on the next cycle; cnt returns to 0; accumulator clears.
- Latency: last input beat to m_axis_tvalid is 1 cycle.
- Throughput: one input beat per cycle, sustained, while the output drains.
- s_axis_tready = (cnt≠lim) | ~m_axis_tvalid | m_axis_tready.
  - At cnt=0, compare against the clamped cfg_data, not the stale lim.
  - Non-completing beats are never stalled.
  - A combinational path from m_axis_tready to s_axis_tready is permitted.
- Output stage:
  - m_axis_tvalid clears on m_axis_tready unless a new word loads in the same cycle; if one loads, valid stays 1 and the data updates.
  - m_axis_tdata is stable while valid & ~ready.
- N=1 (cfg=0): every beat is a full word, presented in lane 0 with upper lanes zero.
- RATIO=1: pure register slice.
- s_axis_tvalid low mid-word: cnt and accumulator hold indefinitely.

Optional Feature:
- Macro: AXIS_UPSIZER_TLAST_EN.
- With the macro defined:
  - s_axis_tlast and m_axis_tlast ports exist.
  - An accepted beat with tlast=1 completes the word regardless of cnt; remaining lanes are zero.
  - m_axis_tlast=1 with that word; cnt returns to 0.
  - s_axis_tready treats a tlast beat as completing.
- Without the macro: no tlast ports; words complete only at cnt=lim.

Decomposition:
- Shared package/header (axis_common): RATIO and CNTR_WIDTH derivation, the cfg clamp function, and the lane-select helper.
- The downsizer uses the same items.
- One natural sub-module: axis_out_reg, a single-entry registered output stage (data/valid/ready, areset active-high).
  - Reusable by later blocks migrating to the active-high reset.

Test Plan:
- Continuous packing: cfg=3, beats 0x00000001..0x00000008, tready=1 → two words: 0x00000004_00000003_00000002_00000001, then 0x00000008_00000007_00000006_00000005. Each appears one cycle after its 4th beat; s_axis_tready stays 1 throughout.
- Narrow ratio: cfg=1, beats 0xA, 0xB → m_axis_tdata = 0x00000000_00000000_0000000B_0000000A.
- Passthrough: cfg=0, beat 0xDEADBEEF → lane 0 = 0xDEADBEEF, upper 96 bits zero, one output per beat.
- Backpressure:
  - Setup: cfg=3, m_axis_tready=0 after the first word.
  - Expected: beats 5–7 are accepted, then s_axis_tready=0 at beat 8 and the first word is held stable.
  - Raising tready: first word drains, second word loads in the same cycle, no beat is lost or duplicated.
- cfg change and clamp:
  - cfg changed 3→1 after beat 2 → current word still collects 4 beats; the next word collects 2.
  - cfg=7 with RATIO=4 → behaves as cfg=3.
- Reset mid-word: 2 beats accepted, areset for 1 cycle → next 4 beats form a clean word with no stale lanes; m_axis_tvalid=0 during reset.
- Macro defined: cfg=3, tlast on the 2nd beat (0x1, 0x2) → 0x00000000_00000000_00000002_00000001 with m_axis_tlast=1; the following word starts at lane 0.
